id_ex_stage: RTL and testbench

ID/EX pipeline stage of the single-issue 32-bit core, directly upstream of the execute-stage ALU. It registers decoded operands and control with a valid/ready handshake and honours stall (back-pressure) and flush. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and turns the 2-bit main-decoder ALU op plus funct into the 3-bit ALU control code that the ALU consumes.

---
 rtl/id_ex_stage_pkg.sv | 40 ++++
 rtl/alu_control_decode.sv | 36 +++
 rtl/id_ex_stage.sv | 144 ++++++++++++++
 tb/tb_id_ex_stage.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage: ALU control codes,
// main-decoder ALU op codes, R-type funct values and the control bundle.
package id_ex_stage_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_OR    = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // Control fields carried from decode into execute.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [5:0] funct;
    } idex_ctrl_t;

endpackage

// File: rtl/alu_control_decode.sv
// Turns the 2-bit main-decoder ALU op plus funct into the 3-bit ALU control
// code. Unknown R-type funct values fall back to add and raise illegal.
module alu_control_decode
    import id_ex_stage_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       illegal
);

    // Combinational op/funct to ALU control mapping, add by default.
    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_OR:  alu_control = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default: begin
                        alu_control = ALU_ADD;
                        illegal     = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush, EX/MEM and
// MEM/WB operand forwarding, and ALU control decode.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [1:0]        in_alu_op,
    input  logic [5:0]        in_funct,
    input  logic              in_alu_src,
    input  logic              in_reg_dst,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_mem_to_reg,
    input  logic              exmem_reg_write,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_control,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_AW-1:0] out_dest,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_mem_to_reg,
    output logic              out_illegal
);

    logic              valid_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [REG_AW-1:0] dest_q;
    idex_ctrl_t        ctrl_q;

    logic              transfer_in;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic              illegal_raw;

    // EX/MEM is the younger producer so it wins; register 0 is hardwired zero.
    function automatic logic [DATA_W-1:0] forward(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] held,
        input logic              ex_we,
        input logic [REG_AW-1:0] ex_rd,
        input logic [DATA_W-1:0] ex_val,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd,
        input logic [DATA_W-1:0] wb_val
    );
        if (ex_we && (ex_rd != '0) && (ex_rd == src)) begin
            return ex_val;
        end
        if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
            return wb_val;
        end
        return held;
    endfunction

    assign in_ready    = !valid_q || out_ready;
    assign transfer_in = in_valid && in_ready;

    // Stage register: flush squashes first, then capture, then drain on hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dest_q    <= '0;
            ctrl_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (transfer_in) begin
            valid_q   <= 1'b1;
            rs_data_q <= in_rs_data;
            rt_data_q <= in_rt_data;
            imm_q     <= in_imm;
            rs_q      <= in_rs;
            rt_q      <= in_rt;
            dest_q    <= in_reg_dst ? in_rd : in_rt;
            ctrl_q    <= '{reg_write:  in_reg_write,
                           mem_read:   in_mem_read,
                           mem_write:  in_mem_write,
                           mem_to_reg: in_mem_to_reg,
                           alu_src:    in_alu_src,
                           alu_op:     in_alu_op,
                           funct:      in_funct};
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Operand forwarding on the held indices, re-evaluated every cycle so a stalled instruction tracks writeback.
    always_comb begin
        fwd_rs = forward(rs_q, rs_data_q, exmem_reg_write, exmem_rd, exmem_result,
                         memwb_reg_write, memwb_rd, memwb_result);
        fwd_rt = forward(rt_q, rt_data_q, exmem_reg_write, exmem_rd, exmem_result,
                         memwb_reg_write, memwb_rd, memwb_result);
    end

    alu_control_decode u_alu_control_decode (
        .alu_op      (ctrl_q.alu_op),
        .funct       (ctrl_q.funct),
        .alu_control (alu_control),
        .illegal     (illegal_raw)
    );

    assign out_valid      = valid_q;
    assign alu_a          = fwd_rs;
    assign alu_b          = ctrl_q.alu_src ? imm_q : fwd_rt;
    assign out_store_data = fwd_rt;
    assign out_dest       = dest_q;
    assign out_reg_write  = valid_q && ctrl_q.reg_write;
    assign out_mem_read   = valid_q && ctrl_q.mem_read;
    assign out_mem_write  = valid_q && ctrl_q.mem_write;
    assign out_mem_to_reg = ctrl_q.mem_to_reg;
    assign out_illegal    = valid_q && illegal_raw;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver pushes expected instructions,
// a monitor compares whatever the stage presents against a reference model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, in_ready;
    logic [31:0] in_rs_data, in_rt_data, in_imm;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [1:0]  in_alu_op;
    logic [5:0]  in_funct;
    logic        in_alu_src, in_reg_dst, in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        out_valid, out_ready;
    logic [31:0] alu_a, alu_b, out_store_data;
    logic [2:0]  alu_control;
    logic [4:0]  out_dest;
    logic        out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_illegal;

    typedef struct {
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
        logic [1:0]  alu_op;
        logic [5:0]  funct;
        logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
        logic        in_valid, flush, out_ready;
        logic        ex_we;
        logic [4:0]  ex_rd;
        logic [31:0] ex_res;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_res;
    } stim_t;

    typedef struct {
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, dest;
        logic        alu_src;
        logic [2:0]  ctl;
        logic        illegal;
        logic [3:0]  ctrl4;
    } exp_t;

    exp_t  exp_q[$];
    bit    model_full = 1'b0;
    int    checks = 0;
    int    errors = 0;
    stim_t idle;
    stim_t s;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_alu_op(in_alu_op), .in_funct(in_funct),
        .in_alu_src(in_alu_src), .in_reg_dst(in_reg_dst),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .out_store_data(out_store_data), .out_dest(out_dest),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
        .out_illegal(out_illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // ALU control table: {illegal, code}
    function automatic logic [3:0] refDecode(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'd0) return {1'b0, 3'd2};
        if (op == 2'd1) return {1'b0, 3'd6};
        if (op == 2'd3) return {1'b0, 3'd1};
        case (f)
            6'h20:   return {1'b0, 3'd2};
            6'h22:   return {1'b0, 3'd6};
            6'h24:   return {1'b0, 3'd0};
            6'h25:   return {1'b0, 3'd1};
            6'h2A:   return {1'b0, 3'd7};
            default: return {1'b1, 3'd2};
        endcase
    endfunction

    // Value an operand should carry given the writeback traffic the bench is driving now.
    function automatic logic [31:0] refFwd(input logic [4:0] idx, input logic [31:0] held);
        if (idx == 5'd0) return held;
        if (exmem_reg_write && exmem_rd == idx) return exmem_result;
        if (memwb_reg_write && memwb_rd == idx) return memwb_result;
        return held;
    endfunction

    function automatic stim_t mkInstr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [1:0] op, input logic [5:0] f);
        stim_t t;
        t = idle;
        t.rs = rs; t.rt = rt; t.rd = rd;
        t.rs_data = a; t.rt_data = b; t.imm = 32'h0000_0040;
        t.alu_op = op; t.funct = f;
        t.reg_dst = 1'b1; t.reg_write = 1'b1;
        t.in_valid = 1'b1; t.out_ready = 1'b1;
        return t;
    endfunction

    function automatic stim_t randStim();
        stim_t t;
        logic [5:0] fl [6];
        fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24; fl[3] = 6'h25; fl[4] = 6'h2A;
        fl[5] = 6'($urandom);
        t.rs = 5'($urandom_range(0, 3)); t.rt = 5'($urandom_range(0, 3)); t.rd = 5'($urandom_range(0, 3));
        t.rs_data = $urandom; t.rt_data = $urandom; t.imm = $urandom;
        t.alu_op = 2'($urandom_range(0, 3));
        t.funct = fl[$urandom_range(0, 5)];
        t.alu_src = 1'($urandom_range(0, 1)); t.reg_dst = 1'($urandom_range(0, 1));
        t.reg_write = 1'($urandom_range(0, 1)); t.mem_read = 1'($urandom_range(0, 1));
        t.mem_write = 1'($urandom_range(0, 1)); t.mem_to_reg = 1'($urandom_range(0, 1));
        t.in_valid = ($urandom_range(0, 9) < 7);
        t.out_ready = ($urandom_range(0, 9) < 7);
        t.flush = ($urandom_range(0, 19) == 0);
        t.ex_we = 1'($urandom_range(0, 1)); t.ex_rd = 5'($urandom_range(0, 3)); t.ex_res = $urandom;
        t.wb_we = 1'($urandom_range(0, 1)); t.wb_rd = 5'($urandom_range(0, 3)); t.wb_res = $urandom;
        return t;
    endfunction

    // One cycle of stimulus: drive on the falling edge, check handshake, then update the model.
    task automatic applyStimulus(input stim_t t);
        exp_t n;
        bit   in_x;
        bit   out_x;
        @(negedge clk);
        in_rs_data = t.rs_data; in_rt_data = t.rt_data; in_imm = t.imm;
        in_rs = t.rs; in_rt = t.rt; in_rd = t.rd;
        in_alu_op = t.alu_op; in_funct = t.funct;
        in_alu_src = t.alu_src; in_reg_dst = t.reg_dst;
        in_reg_write = t.reg_write; in_mem_read = t.mem_read;
        in_mem_write = t.mem_write; in_mem_to_reg = t.mem_to_reg;
        in_valid = t.in_valid; flush = t.flush; out_ready = t.out_ready;
        exmem_reg_write = t.ex_we; exmem_rd = t.ex_rd; exmem_result = t.ex_res;
        memwb_reg_write = t.wb_we; memwb_rd = t.wb_rd; memwb_result = t.wb_res;
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, (!model_full || t.out_ready)});
        check("out_valid", {31'd0, out_valid}, {31'd0, model_full});
        n.rs_data = t.rs_data; n.rt_data = t.rt_data; n.imm = t.imm;
        n.rs = t.rs; n.rt = t.rt; n.dest = t.reg_dst ? t.rd : t.rt;
        n.alu_src = t.alu_src;
        {n.illegal, n.ctl} = refDecode(t.alu_op, t.funct);
        n.ctrl4 = {t.reg_write, t.mem_read, t.mem_write, t.mem_to_reg};
        #2;
        if (t.flush) begin
            if (model_full) void'(exp_q.pop_front());
            model_full = 1'b0;
        end else begin
            in_x  = t.in_valid && (!model_full || t.out_ready);
            out_x = model_full && t.out_ready;
            if (in_x) begin
                exp_q.push_back(n);
                model_full = 1'b1;
            end else if (out_x) begin
                model_full = 1'b0;
            end
        end
    endtask

    // Compare the presented instruction against the scoreboard head; pop on hand-off.
    task automatic checkOutput();
        exp_t e;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid actual=1 required=0");
            end else begin
                e = exp_q[0];
                check("alu_a", alu_a, refFwd(e.rs, e.rs_data));
                check("alu_b", alu_b, e.alu_src ? e.imm : refFwd(e.rt, e.rt_data));
                check("store_data", out_store_data, refFwd(e.rt, e.rt_data));
                check("alu_control", {29'd0, alu_control}, {29'd0, e.ctl});
                check("out_dest", {27'd0, out_dest}, {27'd0, e.dest});
                check("out_illegal", {31'd0, out_illegal}, {31'd0, e.illegal});
                check("ctrl", {28'd0, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg},
                      {28'd0, e.ctrl4});
                if (out_ready && !flush) void'(exp_q.pop_front());
            end
        end else begin
            check("bubble_ctrl", {28'd0, out_reg_write, out_mem_read, out_mem_write, out_illegal}, 32'd0);
        end
    endtask

    // Monitor runs between the driver's handshake checks and its model update.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) checkOutput();
    end

    task automatic checkResetState(input string tag);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_alu_a"}, alu_a, 32'd0);
        check({tag, "_alu_b"}, alu_b, 32'd0);
        check({tag, "_alu_control"}, {29'd0, alu_control}, 32'd2);
        check({tag, "_out_dest"}, {27'd0, out_dest}, 32'd0);
        check({tag, "_ctrl"}, {27'd0, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_illegal}, 32'd0);
    endtask

    initial begin
        idle = '{default: '0};
        idle.out_ready = 1'b1;
        rst_n = 1'b0;
        in_rs_data = '0; in_rt_data = '0; in_imm = '0;
        in_rs = '0; in_rt = '0; in_rd = '0; in_alu_op = '0; in_funct = '0;
        in_alu_src = 1'b0; in_reg_dst = 1'b0; in_reg_write = 1'b0; in_mem_read = 1'b0;
        in_mem_write = 1'b0; in_mem_to_reg = 1'b0; in_valid = 1'b0; flush = 1'b0;
        out_ready = 1'b1;
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
        #1;
        checkResetState("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // back-to-back adds, no hazards
        applyStimulus(mkInstr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 2'b10, 6'h20));
        applyStimulus(mkInstr(5'd1, 5'd2, 5'd3, 32'd11, 32'd13, 2'b10, 6'h20));
        applyStimulus(idle);

        // EX/MEM forward on a held rs=3, then MEM/WB also matching
        applyStimulus(mkInstr(5'd3, 5'd4, 5'd5, 32'hAAAA, 32'hBBBB, 2'b00, 6'h00));
        s = idle; s.out_ready = 1'b0;
        s.ex_we = 1'b1; s.ex_rd = 5'd3; s.ex_res = 32'h1234;
        applyStimulus(s);
        check("fwd_exmem", alu_a, 32'h1234);
        s.wb_we = 1'b1; s.wb_rd = 5'd3; s.wb_res = 32'h9999;
        applyStimulus(s);
        check("fwd_exmem_priority", alu_a, 32'h1234);
        applyStimulus(idle);

        // register 0 is never forwarded
        applyStimulus(mkInstr(5'd0, 5'd1, 5'd2, 32'd0, 32'd9, 2'b00, 6'h00));
        s = idle; s.out_ready = 1'b0;
        s.ex_we = 1'b1; s.ex_rd = 5'd0; s.ex_res = 32'hFFFF;
        applyStimulus(s);
        check("reg0_guard", alu_a, 32'd0);
        applyStimulus(idle);

        // stall three cycles with a new instruction waiting, then a late MEM/WB forward
        applyStimulus(mkInstr(5'd1, 5'd2, 5'd3, 32'h10, 32'h20, 2'b10, 6'h22));
        s = mkInstr(5'd2, 5'd3, 5'd1, 32'h30, 32'h40, 2'b10, 6'h24);
        s.out_ready = 1'b0;
        repeat (3) applyStimulus(s);
        s.wb_we = 1'b1; s.wb_rd = 5'd2; s.wb_res = 32'h5555;
        applyStimulus(s);
        check("stall_wb_fwd_alu_b", alu_b, 32'h5555);
        s.wb_we = 1'b0; s.out_ready = 1'b1;
        applyStimulus(s);

        // flush while stalled: held instruction dropped, incoming not captured
        s = mkInstr(5'd3, 5'd3, 5'd3, 32'h77, 32'h88, 2'b01, 6'h00);
        s.out_ready = 1'b0; s.flush = 1'b1;
        applyStimulus(s);
        s = idle; s.out_ready = 1'b0;
        applyStimulus(s);
        check("flush_reg_write", {31'd0, out_reg_write}, 32'd0);
        applyStimulus(idle);

        // decode sweep: slt, then an unsupported funct
        applyStimulus(mkInstr(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 2'b10, 6'h2A));
        s = idle; s.out_ready = 1'b0;
        applyStimulus(s);
        check("decode_slt", {29'd0, alu_control}, 32'd7);
        s = mkInstr(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 2'b10, 6'h27);
        applyStimulus(s);
        s = idle; s.out_ready = 1'b0;
        applyStimulus(s);
        check("decode_illegal_ctl", {29'd0, alu_control}, 32'd2);
        check("decode_illegal_flag", {31'd0, out_illegal}, 32'd1);

        // reset mid-stall
        #1 rst_n = 1'b0;
        #1;
        checkResetState("midreset");
        exp_q.delete();
        model_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(idle);
        applyStimulus(mkInstr(5'd2, 5'd1, 5'd0, 32'hDEAD, 32'hBEEF, 2'b11, 6'h00));
        applyStimulus(idle);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            applyStimulus(randStim());
        end
        s = idle;
        repeat (4) applyStimulus(s);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
